// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: opcode encodings, FSM states and opcode decode helpers for the MDU
package mul_div_unit_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'b000;
    localparam logic [2:0] MDU_OP_MULTU = 3'b001;
    localparam logic [2:0] MDU_OP_DIV   = 3'b010;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return op inside {MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU};
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return op == MDU_OP_DIV || op == MDU_OP_DIVU;
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return op == MDU_OP_MULT || op == MDU_OP_DIV;
    endfunction

endpackage

// File: rtl/mul_div_unit_iter_step.sv
// mdu_iter_step: one combinational radix-2 step, shift-add multiply or restoring-divide trial subtract
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_op2,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_diff;
    logic           w_fit;

    // multiply: lo holds the multiplier, consumed LSB first while the product shifts in from the top
    assign w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_op2} : '0);
    // divide: lo holds the dividend, consumed MSB first while quotient bits shift in from the bottom
    assign w_rem  = {i_hi, i_lo[WIDTH-1]};
    assign w_diff = w_rem - {1'b0, i_op2};
    assign w_fit  = ~w_diff[WIDTH];

    assign o_hi = i_div ? (w_fit ? w_diff[WIDTH-1:0] : w_rem[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign o_lo = i_div ? {i_lo[WIDTH-2:0], w_fit} : {w_sum[0], i_lo[WIDTH-1:1]};

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO with architectural HI/LO.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU complete at once and leave HI/LO alone.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       MDUOp,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_wh, r_wl, r_b, r_hi, r_lo;
    logic               r_div, r_dzp, r_neg_q, r_neg_r;
    logic               r_busy, r_done, r_dz;
    logic               w_x_neg, w_y_neg, w_div, w_y_zero;
    logic [WIDTH-1:0]   w_ax, w_ay, w_step_hi, w_step_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_x_neg    = is_signed_op(MDUOp) & x[WIDTH-1];
    assign w_y_neg    = is_signed_op(MDUOp) & y[WIDTH-1];
    assign w_ax       = w_x_neg ? -x : x;
    assign w_ay       = w_y_neg ? -y : y;
    assign w_div      = is_div_op(MDUOp) & DIV_EN;
    assign w_y_zero   = y == '0;
    assign w_prod     = {r_wh, r_wl};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_hi  (r_wh),
        .i_lo  (r_wl),
        .i_op2 (r_b),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wh    <= '0;
            r_wl    <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_dzp   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    if (MDUOp == MDU_OP_MTHI) begin
                        r_hi   <= x;
                        r_done <= 1'b1;
                    end else if (MDUOp == MDU_OP_MTLO) begin
                        r_lo   <= x;
                        r_done <= 1'b1;
                    end else if (is_div_op(MDUOp) && !DIV_EN) begin
                        r_done <= 1'b1;
                    end else if (is_iter_op(MDUOp)) begin
                        // the step module adds r_b for multiply and subtracts it for divide
                        r_state <= (w_div && w_y_zero) ? ST_FIX : ST_ITER;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= w_div;
                        r_dzp   <= w_div && w_y_zero;
                        r_b     <= w_div ? w_ay : w_ax;
                        r_wl    <= w_div ? w_ax : w_ay;
                        r_wh    <= (w_div && w_y_zero) ? x : '0;
                        r_neg_q <= w_x_neg ^ w_y_neg;
                        r_neg_r <= w_x_neg;
                    end
                end
                ST_ITER: begin
                    r_wh  <= w_step_hi;
                    r_wl  <= w_step_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dz    <= r_dzp;
                    if (r_dzp) begin
                        r_hi <= r_wh;
                        r_lo <= '1;
                    end else if (r_div) begin
                        r_lo <= r_neg_q ? -r_wl : r_wl;
                        r_hi <= r_neg_r ? -r_wh : r_wh;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit; expectations follow MDU_DIV_EN when it is defined
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x = '0, y = '0;
    logic [2:0]  MDUOp = 3'b111;
    logic        start = 1'b0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;
    int edges, busy_n;
    logic dz_s;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .MDUOp(MDUOp), .start(start),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op;
        x = a;
        y = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        MDUOp = 3'b111;
    endtask

    // edges counts the start edge as 1; busy_n counts cycles seen busy up to done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        edges = 1;
        busy_n = int'(busy);
        while (!done && edges < 60) begin
            tick();
            edges++;
            busy_n += int'(busy);
        end
        dz_s = dz;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz", 64'(dz), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        tick();

        issue(3'b001, 32'hFFFF_FFFF, 32'd2);
        chk("multu_busy_e0", 64'(busy), 64'd1);
        repeat (32) tick();
        chk("multu_busy_e32", {63'd0, busy}, 64'd1);
        chk("multu_nodone_e32", 64'(done), 64'd0);
        tick();
        chk("multu_done_e33", 64'(done), 64'd1);
        chk("multu_busy_e33", 64'(busy), 64'd0);
        chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        tick();
        chk("multu_done_pulse", 64'(done), 64'd0);

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_edges", 64'(edges), 64'd34);
        chk("multu_max_busy", 64'(busy_n), 64'd33);
        chk("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(3'b000, 32'h8000_0000, 32'h8000_0000);
        chk("mult_minmin", {hi, lo}, 64'h4000_0000_0000_0000);

        run_op(3'b000, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_edges", 64'(edges), 64'd34);
        chk("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

`ifdef MDU_DIV_EN
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("div_edges", 64'(edges), 64'd34);
        chk("div_dz", 64'(dz_s), 64'd0);
        chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b011, 32'd100, 32'd7);
        chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(3'b010, 32'd7, 32'hFFFF_FFFE);
        chk("div_negdiv_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        run_op(3'b011, 32'd5, 32'd0);
        chk("divz_edges", 64'(edges), 64'd2);
        chk("divz_dz", 64'(dz_s), 64'd1);
        chk("divz_busy", 64'(busy_n), 64'd1);
        chk("divz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        tick();
        chk("divz_dz_pulse", {dz, done}, 64'd0);
`else
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv_edges", 64'(edges), 64'd1);
        chk("nodiv_busy", 64'(busy_n), 64'd0);
        chk("nodiv_dz", 64'(dz_s), 64'd0);
        chk("nodiv_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'b011, 32'd5, 32'd0);
        chk("nodivz_edges", 64'(edges), 64'd1);
        chk("nodivz_dz", 64'(dz_s), 64'd0);
        chk("nodivz_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`endif

        run_op(3'b100, 32'h1234, 32'd0);
        chk("mthi_edges", 64'(edges), 64'd1);
        chk("mthi_busy", 64'(busy_n), 64'd0);
        chk("mthi_hi", 64'(hi), 64'h1234);
        run_op(3'b101, 32'h5678, 32'd0);
        chk("mtlo_busy", 64'(busy_n), 64'd0);
        chk("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});

        issue(3'b111, 32'hAAAA_AAAA, 32'd1);
        chk("nop_done", {62'd0, busy, done}, 64'd0);
        tick();
        chk("nop_done2", 64'(done), 64'd0);
        chk("nop_hilo", {hi, lo}, {32'h1234, 32'h5678});

        issue(3'b001, 32'd3, 32'd4);
        repeat (3) tick();
        issue(3'b100, 32'hDEAD, 32'd0);
        edges = 5;
        while (!done && edges < 60) begin
            tick();
            edges++;
        end
        chk("busy_ignore_edges", 64'(edges), 64'd34);
        chk("busy_ignore_hilo", {hi, lo}, {32'd0, 32'd12});

        run_op(3'b001, 32'd5, 32'd6);
        chk("b2b_edges", 64'(edges), 64'd34);
        chk("b2b_hilo", {hi, lo}, {32'd0, 32'd30});
        tick();
        chk("b2b_no_extra_done", 64'(done), 64'd0);

        issue(3'b000, 32'h10, 32'h20);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (30) begin
            tick();
            if (done) chk("abort_late_done", 64'(done), 64'd0);
        end
        run_op(3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        chk("after_abort_edges", 64'(edges), 64'd34);
        chk("after_abort_hilo", {hi, lo}, 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
